fsm_stream_ctrl: RTL and testbench

Sequencing controller for the board's serial sequence-detector FSM. It latches a bit pattern and shifts it MSB-first into the detector, one bit per prescaled tick. It counts the detector's hit indications and shows the hit count on the 7-segment display. It sits between the push-button/switch front end and the detector, replacing free-running manual stimulus with a repeatable, handshaked run.

---
 rtl/fsm_stream_ctrl_pkg.sv | 39 +++
 rtl/fsm_stream_ctrl_if.sv | 25 ++
 rtl/fsm_stream_ctrl_tick_gen.sv | 25 ++
 rtl/fsm_stream_ctrl.sv | 103 ++++++++++
 tb/tb_fsm_stream_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fsm_stream_ctrl_pkg.sv
// Shared types and helpers for the detector sequencing controller.
package fsm_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LOAD      = 3'd1,
    S_WAIT_TICK = 3'd2,
    S_DRIVE     = 3'd3,
    S_SAMPLE    = 3'd4,
    S_DONE      = 3'd5
  } state_e;

  localparam int unsigned PRESCALE_DEF = 20000000;

  // Active-low 7-segment pattern, bit order {a,b,c,d,e,f,g}
  function automatic logic [6:0] seg_hex(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'b0000001;
      4'h1: s = 7'b1001111;
      4'h2: s = 7'b0010010;
      4'h3: s = 7'b0000110;
      4'h4: s = 7'b1001100;
      4'h5: s = 7'b0100100;
      4'h6: s = 7'b0100000;
      4'h7: s = 7'b0001111;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0000100;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b1100000;
      4'hC: s = 7'b0110001;
      4'hD: s = 7'b1000010;
      4'hE: s = 7'b0110000;
      default: s = 7'b0111000;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/fsm_stream_ctrl_if.sv
// Handshake and detector-side signals of the sequencing controller.
interface fsm_stream_ctrl_if #(
  parameter int unsigned CNT_W = 8
);
  logic             start;
  logic [31:0]      pat;
  logic [5:0]       pat_len;
  logic             busy;
  logic             done;
  logic             det_en;
  logic             det_x;
  logic             det_hit_n;
  logic [CNT_W-1:0] hit_cnt;
  logic [6:0]       seg;

  modport master (
    output start, pat, pat_len, det_hit_n,
    input  busy, done, det_en, det_x, hit_cnt, seg
  );

  modport slave (
    input  start, pat, pat_len, det_hit_n,
    output busy, done, det_en, det_x, hit_cnt, seg
  );
endinterface

// File: rtl/fsm_stream_ctrl_tick_gen.sv
// Free-running prescaler: one-cycle tick when the count reaches PRESCALE-1.
module tick_gen #(
  parameter int unsigned PRESCALE = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  output logic tick_o
);
  localparam int unsigned W = (PRESCALE > 2) ? $clog2(PRESCALE) : 2;

  logic [W-1:0] cnt_q, cnt_d;

  assign tick_o = (cnt_q == W'(PRESCALE - 1));

  always_comb begin
    cnt_d = cnt_q + W'(1);
    if (clr_i || tick_o) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
endmodule

// File: rtl/fsm_stream_ctrl.sv
// Shifts a latched pattern MSB-first into the sequence detector and counts its hits.
module fsm_stream_ctrl
  import fsm_pkg::*;
#(
  parameter int unsigned PRESCALE = PRESCALE_DEF,
  parameter int unsigned CNT_W    = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  fsm_stream_ctrl_if.slave    bus
);
  state_e           state_q, state_d;
  logic [31:0]      pat_q, pat_d;
  logic [4:0]       idx_q, idx_d;
  logic [CNT_W-1:0] hit_q, hit_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             en_q, en_d;
  logic             x_q, x_d;
  logic             tick_clr, tick;
  logic [5:0]       len_c;

  assign len_c = (bus.pat_len > 6'd32) ? 6'd32 : bus.pat_len;

  tick_gen #(.PRESCALE(PRESCALE)) u_tick (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (tick_clr),
    .tick_o (tick)
  );

  always_comb begin
    state_d  = state_q;
    pat_d    = pat_q;
    idx_d    = idx_q;
    hit_d    = hit_q;
    tick_clr = 1'b0;
    case (state_q)
      S_IDLE: begin
        // Clear on entry so the count is already 0 during LOAD; the first
        // strobe then lands exactly PRESCALE cycles after LOAD.
        if (bus.start) begin
          state_d  = S_LOAD;
          tick_clr = 1'b1;
        end
      end
      S_LOAD: begin
        pat_d   = bus.pat;
        idx_d   = 5'(len_c - 6'd1);
        hit_d   = '0;
        state_d = (len_c == 6'd0) ? S_DONE : S_WAIT_TICK;
      end
      S_WAIT_TICK: if (tick) state_d = S_DRIVE;
      S_DRIVE:     state_d = S_SAMPLE;
      S_SAMPLE: begin
        if (!bus.det_hit_n && (hit_q != '1)) hit_d = hit_q + CNT_W'(1);
        if (idx_q == 5'd0) begin
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q - 5'd1;
          state_d = S_WAIT_TICK;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d == S_LOAD) || (state_d == S_WAIT_TICK) ||
             (state_d == S_DRIVE) || (state_d == S_SAMPLE);
    done_d = (state_d == S_DONE);
    en_d   = (state_d == S_DRIVE);
    x_d    = en_d ? pat_q[idx_q] : 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pat_q   <= '0;
      idx_q   <= '0;
      hit_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      en_q    <= 1'b0;
      x_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      idx_q   <= idx_d;
      hit_q   <= hit_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      en_q    <= en_d;
      x_q     <= x_d;
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.det_en  = en_q;
  assign bus.det_x   = x_q;
  assign bus.hit_cnt = hit_q;
  assign bus.seg     = seg_hex(hit_q[3:0]);
endmodule

// File: tb/tb_fsm_stream_ctrl.sv
// Bench for fsm_stream_ctrl with an overlapping "101" Moore detector model.
module tb_fsm_stream_ctrl;
  localparam int unsigned PS = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fsm_stream_ctrl_if #(.CNT_W(8)) bus();

  fsm_stream_ctrl #(.PRESCALE(PS), .CNT_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Detector stand-in: y low once the last three accepted bits are 1,0,1
  logic        det_rst = 1'b1;
  logic [2:0]  hist;
  int unsigned nbits;
  always @(posedge clk) begin
    if (det_rst) begin
      hist  <= 3'b000;
      nbits <= 0;
    end else if (bus.det_en === 1'b1) begin
      hist <= {hist[1:0], bus.det_x};
      if (nbits < 3) nbits <= nbits + 1;
    end
  end
  assign bus.det_hit_n = !((nbits >= 3) && (hist == 3'b101));

  // Strobe / done recorder, never cleared; tasks take snapshots
  int unsigned st_cyc[$];
  logic        st_x[$];
  int unsigned done_n = 0;
  int unsigned done_at = 0;
  int unsigned xviol = 0;
  always @(negedge clk) begin
    if (bus.det_en === 1'b1) begin
      st_cyc.push_back(cyc);
      st_x.push_back(bus.det_x);
    end else if (bus.det_x !== 1'b0) begin
      xviol++;
    end
    if (bus.done === 1'b1) begin
      done_n++;
      done_at = cyc;
    end
  end

  logic [6:0] seg_t [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  function automatic int unsigned ref_hits(input logic [31:0] p, input int unsigned n);
    int unsigned h = 0;
    logic b [32];
    for (int k = 0; k < int'(n); k++) b[k] = p[n - 1 - k];
    for (int k = 2; k < int'(n); k++)
      if (b[k-2] == 1'b1 && b[k-1] == 1'b0 && b[k] == 1'b1 && h < 255) h++;
    return h;
  endfunction

  task automatic sync();
    @(negedge clk);
    #1;
  endtask

  task automatic do_run(input logic [31:0] p, input int unsigned len, input bit inject,
                        input string tag);
    int unsigned n, s, n0, d0, x0, budget, exp_h, exp_done, got_n;
    bit seen, injected;
    n = (len > 32) ? 32 : len;
    exp_h = ref_hits(p, n);
    det_rst = 1'b1;
    sync();
    det_rst = 1'b0;
    n0 = st_cyc.size();
    d0 = done_n;
    x0 = xviol;
    bus.pat = p;
    bus.pat_len = 6'(len);
    bus.start = 1'b1;
    s = cyc;
    sync();
    bus.start = 1'b0;
    total++;
    if (bus.busy !== 1'b1) begin
      bad++;
      $display("FAIL %s busy_in_load: got %b want 1", tag, bus.busy);
    end
    seen = 0;
    injected = 0;
    budget = 4 * n + 20;
    while (!seen && budget > 0) begin
      if (done_n != d0) seen = 1;
      else begin
        if (inject && !injected && (st_cyc.size() - n0 == 2)) begin
          bus.start = 1'b1;
          bus.pat = ~p;
          bus.pat_len = 6'd5;
          injected = 1;
        end else begin
          bus.start = 1'b0;
        end
        sync();
        budget--;
      end
    end
    bus.start = 1'b0;
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL %s done_timeout: got none want done", tag);
    end
    exp_done = (n == 0) ? s + 2 : s + 4 * n + 3;
    total++;
    if (done_at != exp_done) begin
      bad++;
      $display("FAIL %s done_cycle: got %0d want %0d", tag, done_at - s, exp_done - s);
    end
    total++;
    if (bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL %s busy_at_done: got %b want 0", tag, bus.busy);
    end
    got_n = st_cyc.size() - n0;
    total++;
    if (got_n != n) begin
      bad++;
      $display("FAIL %s strobe_count: got %0d want %0d", tag, got_n, n);
    end
    for (int k = 0; k < int'(n) && k < int'(got_n); k++) begin
      total++;
      if (st_x[n0 + k] !== p[n - 1 - k]) begin
        bad++;
        $display("FAIL %s det_x[%0d]: got %b want %b", tag, k, st_x[n0 + k], p[n - 1 - k]);
      end
      total++;
      if (st_cyc[n0 + k] != s + 5 + 4 * k) begin
        bad++;
        $display("FAIL %s strobe_cycle[%0d]: got %0d want %0d", tag, k,
                 st_cyc[n0 + k] - s, 5 + 4 * k);
      end
    end
    total++;
    if (bus.hit_cnt !== 8'(exp_h)) begin
      bad++;
      $display("FAIL %s hit_cnt: got %0d want %0d", tag, bus.hit_cnt, exp_h);
    end
    total++;
    if (bus.seg !== seg_t[exp_h[3:0]]) begin
      bad++;
      $display("FAIL %s seg: got %b want %b", tag, bus.seg, seg_t[exp_h[3:0]]);
    end
    sync();
    sync();
    total++;
    if (done_n - d0 != 1 || bus.busy !== 1'b0 || st_cyc.size() - n0 != got_n) begin
      bad++;
      $display("FAIL %s after_done: got dones=%0d busy=%b strobes=%0d want 1/0/%0d",
               tag, done_n - d0, bus.busy, st_cyc.size() - n0, got_n);
    end
    total++;
    if (bus.hit_cnt !== 8'(exp_h) || xviol != x0) begin
      bad++;
      $display("FAIL %s hold_and_x: got hit=%0d xviol=%0d want %0d/0", tag, bus.hit_cnt,
               xviol - x0, exp_h);
    end
  endtask

  task automatic test_reset();
    int unsigned n0;
    bus.start = 1'b0;
    bus.pat = '0;
    bus.pat_len = '0;
    rst_n = 1'b0;
    #23;
    total++;
    if ({bus.busy, bus.done, bus.det_en, bus.det_x} !== 4'b0000 || bus.hit_cnt !== 8'd0) begin
      bad++;
      $display("FAIL reset_outputs: got b/d/e/x=%b hit=%0d want 0000/0",
               {bus.busy, bus.done, bus.det_en, bus.det_x}, bus.hit_cnt);
    end
    total++;
    if (bus.seg !== 7'b0000001) begin
      bad++;
      $display("FAIL reset_seg: got %b want 0000001", bus.seg);
    end
    sync();
    rst_n = 1'b1;
    n0 = st_cyc.size();
    repeat (12) sync();
    total++;
    if (bus.busy !== 1'b0 || st_cyc.size() != n0 || done_n != 0) begin
      bad++;
      $display("FAIL reset_idle: got busy=%b strobes=%0d dones=%0d want 0/0/0",
               bus.busy, st_cyc.size() - n0, done_n);
    end
  endtask

  task automatic test_basic();
    do_run(32'h0000_002A, 6, 0, "basic");
    total++;
    if (bus.seg !== 7'b0010010) begin
      bad++;
      $display("FAIL basic_seg_two: got %b want 0010010", bus.seg);
    end
  endtask

  task automatic test_no_match();
    do_run(32'h0000_0000, 8, 0, "nomatch");
  endtask

  task automatic test_len_edges();
    do_run($urandom, 0, 0, "len0");
    do_run($urandom, 40, 0, "len40");
    do_run(32'hAAAA_AAAA, 32, 0, "len32_alt");
    do_run($urandom, 1, 0, "len1");
  endtask

  task automatic test_start_busy();
    do_run(32'h0000_00B5, 8, 1, "start_busy");
  endtask

  task automatic test_reset_mid();
    int unsigned n0, d0, budget;
    det_rst = 1'b1;
    sync();
    det_rst = 1'b0;
    n0 = st_cyc.size();
    d0 = done_n;
    bus.pat = 32'h0000_00AA;
    bus.pat_len = 6'd8;
    bus.start = 1'b1;
    sync();
    bus.start = 1'b0;
    budget = 40;
    while (st_cyc.size() - n0 < 3 && budget > 0) begin
      sync();
      budget--;
    end
    total++;
    if (st_cyc.size() - n0 < 3) begin
      bad++;
      $display("FAIL rstmid_wait: got %0d strobes want 3", st_cyc.size() - n0);
    end
    sync();
    sync();
    total++;
    if (bus.hit_cnt !== 8'd1) begin
      bad++;
      $display("FAIL rstmid_pre_hit: got %0d want 1", bus.hit_cnt);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if (bus.busy !== 1'b0 || bus.det_en !== 1'b0 || bus.hit_cnt !== 8'd0 ||
        bus.seg !== 7'b0000001) begin
      bad++;
      $display("FAIL rstmid_abort: got busy=%b en=%b hit=%0d seg=%b want 0/0/0/0000001",
               bus.busy, bus.det_en, bus.hit_cnt, bus.seg);
    end
    repeat (3) sync();
    rst_n = 1'b1;
    repeat (6) sync();
    total++;
    if (done_n != d0 || bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL rstmid_no_done: got dones=%0d busy=%b want 0/0", done_n - d0, bus.busy);
    end
    do_run(32'h0000_00AA, 8, 0, "after_rst");
  endtask

  task automatic test_random();
    for (int i = 0; i < 6; i++)
      do_run($urandom, $urandom_range(0, 40), 0, "random");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_no_match();
    test_len_edges();
    test_start_busy();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
